// File: rtl/count_compare_timer_if.sv
// Handshake and status bundle for count_compare_timer.
// master drives count/load/cancel; slave (the timer) returns status and pulses.
interface count_compare_timer_if #(
    parameter int WIDTH  = 32,
    parameter int FIRE_W = 8
);
    logic [WIDTH-1:0]  count;
    logic              load_valid;
    logic              load_ready;
    logic [WIDTH-1:0]  delta;
    logic              periodic;
    logic              cancel;
    logic              busy;
    logic [WIDTH-1:0]  target;
    logic              irq;
    logic              err;
    logic [FIRE_W-1:0] fire_count;

    modport master (
        output count, load_valid, delta, periodic, cancel,
        input  load_ready, busy, target, irq, err, fire_count
    );

    modport slave (
        input  count, load_valid, delta, periodic, cancel,
        output load_ready, busy, target, irq, err, fire_count
    );
endinterface

// File: rtl/count_compare_timer.sv
// Compare timer on a shared free-running counter: one-shot or periodic irq.
// Ports: clk, reset (sync, active-high), bus (slave modport of the timer interface).
module count_compare_timer #(
    parameter int WIDTH  = 32,
    parameter int FIRE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    count_compare_timer_if.slave bus
);
    typedef enum logic {
        IDLE,
        ARMED
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  target_q;
    logic [WIDTH-1:0]  period_q;
    logic              mode_q;
    logic              irq_q;
    logic              err_q;
    logic [FIRE_W-1:0] fire_q;

    logic [WIDTH-1:0]  add_a;
    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  target_d;
    logic [FIRE_W-1:0] fire_d;
    logic              hit;
    logic              load_ok;

    // A single adder is shared: in IDLE it forms count + delta for a new
    // load, in ARMED it forms target + period for the periodic re-arm.
    always_comb begin
        add_a = target_q;
        add_b = period_q;
        if (state_q == IDLE) begin
            add_a = bus.count;
            add_b = bus.delta;
        end
        target_d = add_a + add_b;
    end

    always_comb begin
        fire_d = fire_q;
        if (!(&fire_q)) begin
            fire_d = fire_q + 1'b1;
        end
    end

    assign hit     = (bus.count == target_q);
    assign load_ok = (bus.delta != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
            fire_q   <= '0;
        end else begin
            irq_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        if (load_ok) begin
                            target_q <= target_d;
                            period_q <= bus.delta;
                            mode_q   <= bus.periodic;
                            fire_q   <= '0;
                            state_q  <= ARMED;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    // cancel takes priority over a same-cycle match
                    if (bus.cancel) begin
                        state_q <= IDLE;
                    end else if (hit) begin
                        irq_q  <= 1'b1;
                        fire_q <= fire_d;
                        if (mode_q) begin
                            target_q <= target_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q == ARMED);
    assign bus.target     = target_q;
    assign bus.irq        = irq_q;
    assign bus.err        = err_q;
    assign bus.fire_count = fire_q;
endmodule

// File: tb/tb_count_compare_timer.sv
// Randomized scoreboard bench for count_compare_timer.
// Expected irq/err events are queued at load time and popped by a monitor.
module tb_count_compare_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    count_compare_timer_if #(.WIDTH(32), .FIRE_W(8)) bus ();

    count_compare_timer #(.WIDTH(32), .FIRE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] cnt;
        logic [31:0] fire;
        logic [31:0] tgt;
    } ev_t;

    ev_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] last_tgt = 0;
    logic [31:0] last_fire = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int k);
        return (k > 255) ? 32'd255 : 32'(k);
    endfunction

    // Monitor: every irq/err pulse must match the oldest queued event.
    always @(negedge clk) begin
        if (bus.irq === 1'b1 || bus.err === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: irq=%0b err=%0b at count %0h",
                         bus.irq, bus.err, bus.count);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_kind", {31'd0, bus.err}, {31'd0, e.is_err});
                chk("ev_count", bus.count, e.cnt);
                chk("ev_fire", {24'd0, bus.fire_count}, e.fire);
                chk("ev_target", bus.target, e.tgt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.count = bus.count + 1;
    endtask

    task automatic do_load(input logic [31:0] d, input bit per);
        bus.load_valid = 1'b1;
        bus.delta = d;
        bus.periodic = per;
        tick();
        bus.load_valid = 1'b0;
        bus.delta = $urandom;
        bus.periodic = $urandom_range(0, 1);
    endtask

    task automatic one_shot(input logic [31:0] d);
        logic [31:0] c;
        c = bus.count;
        sb.push_back('{1'b0, c + d + 1, 32'd1, c + d});
        do_load(d, 1'b0);
        chk("os_target", bus.target, c + d);
        chk("os_busy", {31'd0, bus.busy}, 32'd1);
        repeat (d) tick();
        chk("os_busy_fall", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("os_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("os_fire", {24'd0, bus.fire_count}, 32'd1);
        last_tgt = c + d;
        last_fire = 1;
    endtask

    task automatic periodic_run(input logic [31:0] d, input int n);
        logic [31:0] c;
        c = bus.count;
        for (int k = 1; k <= n; k++)
            sb.push_back('{1'b0, c + 32'(k) * d + 1, sat(k), c + 32'(k + 1) * d});
        do_load(d, 1'b1);
        chk("per_target", bus.target, c + d);
        repeat (32'(n) * d) tick();
        chk("per_busy", {31'd0, bus.busy}, 32'd1);
        chk("per_fire", {24'd0, bus.fire_count}, sat(n));
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("per_cancel_busy", {31'd0, bus.busy}, 32'd0);
        chk("per_cancel_ready", {31'd0, bus.load_ready}, 32'd1);
        last_tgt = c + 32'(n + 1) * d;
        last_fire = sat(n);
    endtask

    task automatic zero_load();
        logic [31:0] c;
        c = bus.count;
        sb.push_back('{1'b1, c + 1, last_fire, last_tgt});
        do_load(32'd0, $urandom_range(0, 1));
        chk("zero_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("zero_busy", {31'd0, bus.busy}, 32'd0);
        chk("zero_target", bus.target, last_tgt);
        tick();
        chk("zero_err_clear", {31'd0, bus.err}, 32'd0);
    endtask

    task automatic cancel_on_match(input logic [31:0] d);
        logic [31:0] c;
        c = bus.count;
        do_load(d, $urandom_range(0, 1));
        repeat (d - 1) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cm_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        tick();
        chk("cm_fire", {24'd0, bus.fire_count}, 32'd0);
        last_tgt = c + d;
        last_fire = 0;
    endtask

    initial begin
        bus.count = 32'd50;
        bus.load_valid = 1'b0;
        bus.delta = 32'd0;
        bus.periodic = 1'b0;
        bus.cancel = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("rst_target", bus.target, 32'd0);
        chk("rst_fire", {24'd0, bus.fire_count}, 32'd0);
        tick();

        bus.count = 32'd100;
        one_shot(32'd5);
        bus.count = 32'd0;
        periodic_run(32'd4, 3);
        bus.count = 32'hFFFF_FFFE;
        one_shot(32'd3);
        bus.count = 32'd7;
        zero_load();
        cancel_on_match(32'd5);
        cancel_on_match(32'd1);
        periodic_run(32'd1, 260);

        for (int i = 0; i < 40; i++) begin
            int op;
            if ($urandom_range(0, 3) == 0) bus.count = $urandom;
            else if ($urandom_range(0, 4) == 0)
                bus.count = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            op = $urandom_range(0, 3);
            case (op)
                0: one_shot($urandom_range(1, 30));
                1: periodic_run($urandom_range(1, 8), $urandom_range(1, 4));
                2: zero_load();
                default: cancel_on_match($urandom_range(1, 12));
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end

        bus.count = 32'd200;
        do_load(32'd1000, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rarm_busy", {31'd0, bus.busy}, 32'd0);
        chk("rarm_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("rarm_target", bus.target, 32'd0);
        chk("rarm_fire", {24'd0, bus.fire_count}, 32'd0);
        chk("rarm_irq", {31'd0, bus.irq}, 32'd0);
        chk("rarm_err", {31'd0, bus.err}, 32'd0);

        repeat (5) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/count_compare_timer.md
Name: count_compare_timer

Overview:
Downstream consumer of the free-running 32-bit counter output. It arms a compare target relative to the live count, raises a one-cycle irq pulse when the count reaches the target, and optionally re-arms itself periodically. It provides the timeout and periodic-tick service for logic that shares the counter.

Parameters:
WIDTH, 32, width of count, delta and target.
FIRE_W, 8, width of the saturating fire counter.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
count  input  WIDTH  live counter value; increments by 1 per cycle and wraps modulo 2^WIDTH.
load_valid  input  1  load request.
load_ready  output  1  high when a load can be accepted (IDLE only).
delta  input  WIDTH  offset from the current count; sampled on accept.
periodic  input  1  sampled on accept. 1 = auto-reload every delta cycles; 0 = one-shot.
cancel  input  1  disarm request.
busy  output  1  high in ARMED.
target  output  WIDTH  current compare target (registered).
irq  output  1  one-cycle match pulse.
err  output  1  one-cycle pulse on a rejected load (delta == 0).
fire_count  output  FIRE_W  number of irq pulses since the last accepted load; saturates at all-ones.

Behaviour:
- Reset (reset = 1 at posedge): state = IDLE. busy = 0, irq = 0, err = 0, target = 0, fire_count = 0, stored period = 0, stored mode = 0. Reset overrides every other input on the same edge, including mid-ARMED operation.
- States: IDLE and ARMED. load_ready = (state == IDLE), combinational from state. busy = (state == ARMED).
- Accept: load_valid && load_ready at a posedge.
  - delta != 0: target <= count + delta (mod 2^WIDTH, carry dropped); period <= delta; mode <= periodic; fire_count <= 0; state -> ARMED.
  - delta == 0: handshake completes, err = 1 for the next cycle, state stays IDLE, and no other register changes.
- Match: in ARMED when count == target (equality only, no magnitude compare). irq = 1 for exactly the next cycle. fire_count increments and saturates.
  - One-shot mode: state -> IDLE.
  - Periodic mode: target <= target + period (mod 2^WIDTH) and state stays ARMED, so consecutive pulses are exactly period cycles apart.
- Latency: irq is asserted in the cycle after the cycle where count == target. For a load accepted with count = C, irq is high during the cycle where count = C + delta + 1.
- Wrap-around: if the target sum wraps past 2^WIDTH-1, the match still fires correctly through equality against the wrapped count.
- cancel in ARMED: state -> IDLE on the next edge with no irq. If cancel and a match occur in the same cycle, cancel wins: no irq and fire_count unchanged. cancel in IDLE is ignored. cancel has no effect on load acceptance.
- Upstream count discontinuity (e.g. an upstream reset that zeros count): no detection is performed. The match is missed until count wraps back to target. Software must cancel and reload.
- Outputs that have no event in a cycle hold their values. irq and err are 0 except for their single-cycle pulses.
- Expected RTL size: 2-state FSM, one 32-bit adder, one equality compare, registered outputs.

Test Plan:
- Reset with count = 50, then release -> load_ready = 1, busy = 0, irq = 0, target = 0, fire_count = 0.
- One-shot: accept at count = 100, delta = 5 -> target = 105; single irq while count = 106; busy falls at the same edge; fire_count = 1; load_ready = 1 afterwards.
- Periodic: accept at count = 0, delta = 4 -> irq at count = 5, 9, 13; target steps 4 -> 8 -> 12 -> 16; fire_count = 3 after the third pulse; busy stays 1.
- Wrap: accept at count = 0xFFFFFFFE, delta = 3 -> target = 0x00000001; irq while count = 0x00000002.
- delta = 0 at count = 7 -> err pulse for one cycle, state stays IDLE, target unchanged, no irq.
- Cancel tests:
  - cancel in the same cycle as count == target -> no irq, busy = 0 next cycle, fire_count unchanged.
  - reset asserted while ARMED -> all outputs return to their reset values on the next edge.
